pc_sequencer: RTL
=================

# pc_sequencer

Fetch-stage controller for the 5-stage pipeline. It owns the program counter and sequences instruction-memory requests with one request outstanding at a time. It computes PC+4 through the pipeline's incrementer and arbitrates next-PC sources: trap vector, EX-stage branch target, hold on stall, or sequential. It presents fetched-instruction validity and PC to the IF/ID register and raises the flush for redirects.

## Interface
- RESET_VECTOR, 32'h0000_0000: PC loaded on reset
- TRAP_VECTOR, 32'h0000_0100: PC loaded on trap or misaligned branch target
- clk  in  1  single pipeline clock, rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- stall_i  in  1  decode hazard stall; IF/ID must hold
- br_taken_i  in  1  EX-stage branch/jump resolved taken
- br_target_i  in  32  EX-stage redirect address
- trap_i  in  1  exception request from later stages
- imem_req_o  out  1  instruction fetch request
- imem_addr_o  out  32  fetch address (current PC)
- imem_ready_i  in  1  instruction data valid for the outstanding request
- if_valid_o  out  1  IF/ID may capture the instruction this cycle
- if_pc_o  out  32  PC of the instruction qualified by if_valid_o
- flush_o  out  1  kill IF/ID and ID/EX contents this cycle
- misalign_o  out  1  one-cycle pulse: br_target_i[1:0] != 0 on a taken branch

## Operation
- States: BOOT, REQ, HOLD, DRAIN.
- Reset: pc = RESET_VECTOR, state = BOOT. All outputs are 0 except imem_addr_o and if_pc_o, which equal RESET_VECTOR.
- BOOT: lasts one cycle after rst_n deasserts; no request; goes to REQ.
- REQ: imem_req_o = 1, imem_addr_o = pc.
  - imem_ready_i & !stall_i: if_valid_o = 1, pc <= pc+4, stay in REQ.
  - imem_ready_i & stall_i: if_valid_o = 1 (IF/ID holds), go to HOLD.
  - !imem_ready_i: wait in REQ.
- HOLD: imem_req_o = 0, if_valid_o = 1, if_pc_o = pc. On !stall_i: pc <= pc+4, go to REQ.
- DRAIN: imem_req_o = 0. Discards the response of the pre-redirect request; on imem_ready_i, go to REQ.
- Redirect priority: trap_i > br_taken_i > stall/sequential.
  - A redirect is honoured in REQ, HOLD and DRAIN.
  - A redirect during BOOT is ignored.
- Redirect cycle:
  - flush_o = 1 and if_valid_o = 0 (forced).
  - pc <= TRAP_VECTOR on trap; pc <= br_target_i on branch.
  - If a request was outstanding (REQ & !imem_ready_i, or DRAIN & !imem_ready_i): go to DRAIN. Otherwise go to REQ.
- Misaligned taken branch: misalign_o = 1 and pc <= TRAP_VECTOR (treated as a trap); flush_o = 1.
- Redirect beats stall: a redirect with stall_i = 1 still flushes and loads the new PC.
- Arithmetic: PC+4 is a 32-bit unsigned add; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.

## Timing
- imem_addr_o is registered and changes only on the edge after a pc update.
- if_valid_o, flush_o, misalign_o and imem_req_o are combinational from state, imem_ready_i, stall_i, trap_i and br_taken_i. This path is documented for IF-stage timing closure.
- Latency:
  - Zero-wait memory: one instruction per cycle.
  - First request is issued 1 cycle after reset release.
  - Redirect to new-target request: 1 cycle, or 1 + remaining wait if a request must be drained.
- Reset assertion mid-transaction returns to BOOT immediately. Any late imem_ready_i is ignored until REQ.

## Structure
- Shared package pc_seq_pkg: state enum (BOOT, REQ, HOLD, DRAIN), RESET_VECTOR/TRAP_VECTOR defaults, INSTR_BYTES = 4.
- One sub-module: Adder (PC → PC+4), instantiated once on pc.
- The remaining logic (next-PC mux, FSM, output decode) sits in pc_sequencer.

## Test plan
- Reset and stream: release rst_n with imem_ready_i tied 1 → BOOT for 1 cycle, then if_pc_o = 0, 4, 8, 12 on consecutive cycles with if_valid_o = 1.
- Stall: assert stall_i for 3 cycles while ready at pc = 8 → if_valid_o held at 1, if_pc_o stays 8, no requests; the next fetch is 12.
- Branch with wait states: br_taken_i, target 0x40, while request at 0x10 is pending for 2 more cycles → flush_o pulse, DRAIN swallows the 0x10 response, next if_valid_o has if_pc_o = 0x40.
- Simultaneous trap and branch with stall_i = 1 → pc = 0x100, flush_o = 1, misalign_o = 0.
- Misaligned target 0x42 → misalign_o and flush_o pulse; next fetch at 0x100.
- Wrap-around and reset: stream from 0xFFFF_FFFC → next address 0; assert rst_n low mid-request → outputs return to reset values in the same cycle.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package pc_seq_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEFAULT  = 32'h0000_0100;
  localparam logic [31:0] INSTR_BYTES          = 32'd4;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_REQ,
    ST_HOLD,
    ST_DRAIN
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_adder.sv
// Sequential-PC incrementer: PC + INSTR_BYTES, wrapping modulo 2^32.
module pc_sequencer_adder
  import pc_seq_pkg::*;
(
  input  logic [31:0] pc_i,
  output logic [31:0] pc_next_o
);

  assign pc_next_o = pc_i + INSTR_BYTES;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: owns the PC, issues one imem request at a time and
// arbitrates trap / branch / hold / sequential next-PC sources.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        trap_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic        flush_o,
  output logic        misalign_o
);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        misaligned;
  logic        outstanding;

  pc_sequencer_adder u_adder (
    .pc_i      (pc_q),
    .pc_next_o (pc_plus4)
  );

  // Redirects are ignored while booting; a trap always outranks a branch.
  assign redirect    = (state_q != ST_BOOT) && (trap_i || br_taken_i);
  assign misaligned  = redirect && !trap_i && br_taken_i && (br_target_i[1:0] != 2'b00);
  assign outstanding = ((state_q == ST_REQ) || (state_q == ST_DRAIN)) && !imem_ready_i;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    imem_req_o = 1'b0;
    if_valid_o = 1'b0;
    flush_o    = 1'b0;
    misalign_o = 1'b0;

    unique case (state_q)
      ST_BOOT: state_d = ST_REQ;
      ST_REQ: begin
        imem_req_o = 1'b1;
        if (imem_ready_i) begin
          if_valid_o = 1'b1;
          if (stall_i) state_d = ST_HOLD;
          else         pc_d    = pc_plus4;
        end
      end
      ST_HOLD: begin
        if_valid_o = 1'b1;
        if (!stall_i) begin
          pc_d    = pc_plus4;
          state_d = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (imem_ready_i) state_d = ST_REQ;
      end
      default: state_d = ST_BOOT;
    endcase

    // A redirect overrides the stall/sequential decision made above.
    if (redirect) begin
      flush_o    = 1'b1;
      if_valid_o = 1'b0;
      misalign_o = misaligned;
      pc_d       = (trap_i || misaligned) ? TRAP_VECTOR : br_target_i;
      state_d    = outstanding ? ST_DRAIN : ST_REQ;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign imem_addr_o = pc_q;
  assign if_pc_o     = pc_q;

endmodule
